// File: rtl/thread_dispatch_resp_pkg.sv
// Shared message codes, bus widths, FSM states and result constants for the
// thread dispatcher responder.
package thread_dispatch_resp_pkg;

  localparam int CPU_MSG_SIZE = 4;
  localparam int ADDR_SIZE    = 16;
  localparam int DATA_SIZE    = 16;

  typedef logic [CPU_MSG_SIZE-1:0] cpu_msg_t;

  localparam cpu_msg_t CPU_R_FORK_THRD = 4'h1;
  localparam cpu_msg_t CPU_R_STOP_THRD = 4'h2;
  localparam cpu_msg_t CPU_R_FORK_DONE = 4'h3;
  localparam cpu_msg_t CPU_R_STOP_DONE = 4'h4;

  typedef enum logic [1:0] {
    THRD_ST_IDLE   = 2'd0,
    THRD_ST_SEARCH = 2'd1,
    THRD_ST_RESP   = 2'd2
  } thrd_state_e;

  localparam logic [DATA_SIZE-1:0] THRD_RESULT_FAIL = '1;

  function automatic logic is_thrd_req(input cpu_msg_t msg);
    return (msg == CPU_R_FORK_THRD) || (msg == CPU_R_STOP_THRD);
  endfunction

endpackage

// File: rtl/thread_dispatch_resp_if.sv
// Request/response message bus between the per-CPU thread controllers and the
// dispatcher.
interface thread_dispatch_resp_if;
  import thread_dispatch_resp_pkg::*;

  cpu_msg_t               cpu_msg_in;
  logic                   cpu_msg_pulse;
  logic [ADDR_SIZE-1:0]   addr_in;
  logic [DATA_SIZE-1:0]   data_in;
  cpu_msg_t               cpu_msg_out;
  logic [DATA_SIZE-1:0]   data_out;

  modport master (
    output cpu_msg_in, cpu_msg_pulse, addr_in, data_in,
    input  cpu_msg_out, data_out
  );

  modport slave (
    input  cpu_msg_in, cpu_msg_pulse, addr_in, data_in,
    output cpu_msg_out, data_out
  );

endinterface

// File: rtl/thread_dispatch_resp_slot_table.sv
// thread_slot_table: per-slot valid/code/data storage with one indexed read
// port and one set-or-clear write port.
module thread_slot_table
  import thread_dispatch_resp_pkg::*;
#(
  parameter int NTHREADS = 8,
  parameter int IDX_W    = $clog2(NTHREADS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic                 set_i,
  input  logic [IDX_W-1:0]     widx_i,
  input  logic [ADDR_SIZE-1:0] code_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic [IDX_W-1:0]     ridx_i,
  output logic                 rvalid_o,
  output logic [ADDR_SIZE-1:0] rcode_o,
  output logic [NTHREADS-1:0]  valid_o
);

  logic [NTHREADS-1:0]  valid_q;
  logic [ADDR_SIZE-1:0] code_q [NTHREADS];
  logic [DATA_SIZE-1:0] data_q [NTHREADS];

  // NOTE: the arrays are small register files, so they are reset along with
  // valid; a fresh table after reset holds no stale addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < NTHREADS; i++) begin
        code_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (we_i) begin
      valid_q[widx_i] <= set_i;
      if (set_i) begin
        code_q[widx_i] <= code_i;
        data_q[widx_i] <= data_i;
      end
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rcode_o  = code_q[ridx_i];
  assign valid_o  = valid_q;

endmodule

// File: rtl/thread_dispatch_resp.sv
// Dispatcher responder: FORK/STOP requests scan the slot table one slot per
// enabled cycle and answer with a one-cycle DONE. Option: THRD_DUP_GUARD_EN.
module thread_dispatch_resp
  import thread_dispatch_resp_pkg::*;
#(
  parameter int NTHREADS = 8,
  parameter int IDX_W    = $clog2(NTHREADS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_oe,
  thread_dispatch_resp_if.slave             bus,
  output logic                              disp_online,
  output logic [NTHREADS-1:0]               thrd_valid,
  output logic [$clog2(NTHREADS+1)-1:0]     thread_cnt
);

  localparam int CNT_W = $clog2(NTHREADS+1);

  thrd_state_e          state_q;
  logic                 op_fork_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] data_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  cpu_msg_t             msg_q;
  logic [DATA_SIZE-1:0] dout_q;
  logic                 online_q;

  logic                 rvalid;
  logic [ADDR_SIZE-1:0] rcode;
  logic                 last, done, ok, we;
  logic [IDX_W-1:0]     widx;

`ifdef THRD_DUP_GUARD_EN
  logic             free_found_q, dup_q;
  logic [IDX_W-1:0] free_idx_q;
  logic             free_now, dup_now;
  logic [IDX_W-1:0] free_idx_now;
`endif

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    last = (idx_q == IDX_W'(NTHREADS-1));
    done = 1'b0;
    ok   = 1'b0;
    widx = idx_q;
`ifdef THRD_DUP_GUARD_EN
    dup_now      = dup_q;
    free_now     = free_found_q;
    free_idx_now = free_idx_q;
`endif
    if (state_q == THRD_ST_SEARCH) begin
      if (op_fork_q) begin
`ifdef THRD_DUP_GUARD_EN
        // Full scan: remember the first free slot, reject on any duplicate.
        dup_now      = dup_q | (rvalid && rcode == addr_q);
        free_now     = free_found_q | !rvalid;
        free_idx_now = free_found_q ? free_idx_q : idx_q;
        done         = last;
        ok           = last && free_now && !dup_now;
        widx         = free_idx_now;
`else
        done = !rvalid || last;
        ok   = !rvalid;
`endif
      end else begin
        ok   = rvalid && (rcode == addr_q);
        done = ok || last;
      end
    end
    we = clk_oe && ok;
  end

  thread_slot_table #(.NTHREADS(NTHREADS), .IDX_W(IDX_W)) u_table (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .set_i    (op_fork_q),
    .widx_i   (widx),
    .code_i   (addr_q),
    .data_i   (data_q),
    .ridx_i   (idx_q),
    .rvalid_o (rvalid),
    .rcode_o  (rcode),
    .valid_o  (thrd_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= THRD_ST_IDLE;
      op_fork_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      msg_q     <= '0;
      dout_q    <= '0;
      online_q  <= 1'b0;
`ifdef THRD_DUP_GUARD_EN
      free_found_q <= 1'b0;
      dup_q        <= 1'b0;
      free_idx_q   <= '0;
`endif
    end else if (clk_oe) begin
      online_q <= 1'b1;
      unique case (state_q)
        THRD_ST_IDLE: begin
          if (bus.cpu_msg_pulse && is_thrd_req(bus.cpu_msg_in)) begin
            op_fork_q <= (bus.cpu_msg_in == CPU_R_FORK_THRD);
            addr_q    <= bus.addr_in;
            data_q    <= bus.data_in;
            idx_q     <= '0;
`ifdef THRD_DUP_GUARD_EN
            free_found_q <= 1'b0;
            dup_q        <= 1'b0;
`endif
            state_q   <= THRD_ST_SEARCH;
          end
        end
        THRD_ST_SEARCH: begin
          if (done) begin
            msg_q  <= op_fork_q ? CPU_R_FORK_DONE : CPU_R_STOP_DONE;
            dout_q <= ok ? DATA_SIZE'(widx) : THRD_RESULT_FAIL;
            if (ok) cnt_q <= op_fork_q ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
            state_q <= THRD_ST_RESP;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
`ifdef THRD_DUP_GUARD_EN
            free_found_q <= free_now;
            free_idx_q   <= free_idx_now;
            dup_q        <= dup_now;
`endif
          end
        end
        THRD_ST_RESP: begin
          msg_q   <= '0;
          dout_q  <= '0;
          state_q <= THRD_ST_IDLE;
        end
        default: state_q <= THRD_ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_msg_out = msg_q;
  assign bus.data_out    = dout_q;
  assign disp_online     = online_q;
  assign thread_cnt      = cnt_q;

endmodule

// File: tb/tb_thread_dispatch_resp.sv
// Self-checking bench for thread_dispatch_resp: a slot-table model with a
// per-request latency countdown, directed cases and randomized traffic.
module tb_thread_dispatch_resp;
  import thread_dispatch_resp_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_oe = 1'b1;
  logic oe_rand = 1'b0;
  logic cmp_en = 1'b0;
  logic disp_online;
  logic [N-1:0] thrd_valid;
  logic [3:0]   thread_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  thread_dispatch_resp_if bus ();

  thread_dispatch_resp #(.NTHREADS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_oe      (clk_oe),
    .bus         (bus),
    .disp_online (disp_online),
    .thrd_valid  (thrd_valid),
    .thread_cnt  (thread_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_valid [N];
  logic [15:0]    m_code  [N];
  int             m_phase = 0;
  int             m_left  = 0;
  int             m_slot  = -1;
  bit             m_fork  = 0;
  logic [15:0]    m_addr  = '0;
  cpu_msg_t       m_msg   = '0;
  logic [15:0]    m_data  = '0;
  logic           m_online = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    int f;
    bit dup;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_code[i] = '0; end
      m_phase = 0; m_msg = '0; m_data = '0; m_online = 1'b0;
    end else if (clk_oe) begin
      m_online = 1'b1;
      case (m_phase)
        0: if (bus.cpu_msg_pulse &&
               (bus.cpu_msg_in == CPU_R_FORK_THRD || bus.cpu_msg_in == CPU_R_STOP_THRD)) begin
          m_fork = (bus.cpu_msg_in == CPU_R_FORK_THRD);
          m_addr = bus.addr_in;
          f = -1; dup = 0;
          if (m_fork) begin
            for (int i = 0; i < N; i++) begin
              if (!m_valid[i] && f < 0) f = i;
              if (m_valid[i] && m_code[i] == m_addr) dup = 1;
            end
`ifdef THRD_DUP_GUARD_EN
            m_left = N;
            m_slot = (!dup && f >= 0) ? f : -1;
`else
            m_left = (f >= 0) ? f + 1 : N;
            m_slot = f;
`endif
          end else begin
            for (int i = 0; i < N; i++)
              if (f < 0 && m_valid[i] && m_code[i] == m_addr) f = i;
            m_left = (f >= 0) ? f + 1 : N;
            m_slot = f;
          end
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_msg  = m_fork ? CPU_R_FORK_DONE : CPU_R_STOP_DONE;
            m_data = (m_slot >= 0) ? 16'(m_slot) : 16'hFFFF;
            if (m_slot >= 0) begin
              m_valid[m_slot] = m_fork;
              if (m_fork) m_code[m_slot] = m_addr;
            end
            m_phase = 2;
          end
        end
        default: begin m_msg = '0; m_data = '0; m_phase = 0; end
      endcase
    end
  end

  // ---------------- continuous compare ----------------
  always @(negedge clk) begin
    logic [N-1:0] ev;
    int cnt;
    if (cmp_en) begin
      ev = '0; cnt = 0;
      for (int i = 0; i < N; i++) begin ev[i] = m_valid[i]; cnt += int'(m_valid[i]); end
      check("cpu_msg_out", 32'(bus.cpu_msg_out), 32'(m_msg));
      check("data_out",    32'(bus.data_out),    32'(m_data));
      check("thrd_valid",  32'(thrd_valid),      32'(ev));
      check("thread_cnt",  32'(thread_cnt),      32'(cnt));
      check("disp_online", 32'(disp_online),     32'(m_online));
    end
  end

  always @(negedge clk) begin
    #1 clk_oe = oe_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  function automatic int exp_fork_lat(input int k);
`ifdef THRD_DUP_GUARD_EN
    return N;
`else
    return k + 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_msg",    32'(bus.cpu_msg_out), 32'h0);
    check("rst_data",   32'(bus.data_out),    32'h0);
    check("rst_valid",  32'(thrd_valid),      32'h0);
    check("rst_cnt",    32'(thread_cnt),      32'h0);
    check("rst_online", 32'(disp_online),     32'h0);
    #1 rst = 1'b1;
  endtask

  task automatic wait_enabled_edge();
    int n = 0;
    do begin @(posedge clk); n++; end while (!clk_oe && n < 100);
  endtask

  task automatic req(input cpu_msg_t op, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] res, output cpu_msg_t rmsg);
    int n;
    @(negedge clk); #1;
    bus.cpu_msg_pulse = 1'b1; bus.cpu_msg_in = op; bus.addr_in = a; bus.data_in = d;
    wait_enabled_edge();
    @(negedge clk); #1;
    bus.cpu_msg_pulse = 1'b0; bus.cpu_msg_in = '0;
    bus.addr_in = 16'($urandom); bus.data_in = 16'($urandom);
    lat = 0; n = 0;
    while (n < 200) begin
      @(posedge clk); n++;
      if (clk_oe) lat++;
      #1;
      if (bus.cpu_msg_out != '0) break;
    end
    if (bus.cpu_msg_out == '0)
      check("resp_timeout", 32'(bus.cpu_msg_out),
            32'(op == CPU_R_FORK_THRD ? CPU_R_FORK_DONE : CPU_R_STOP_DONE));
    rmsg = bus.cpu_msg_out;
    res  = bus.data_out;
    wait_enabled_edge(); #1;
    check("resp_one_cycle", 32'(bus.cpu_msg_out), 32'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    logic [15:0] res;
    cpu_msg_t rmsg;
    int seen;

    bus.cpu_msg_pulse = 1'b0; bus.cpu_msg_in = '0; bus.addr_in = '0; bus.data_in = '0;
    do_reset();
    cmp_en = 1'b1;
    @(posedge clk); #1 check("online_after_rst", 32'(disp_online), 32'h1);

    // First FORK lands in slot 0.
    req(CPU_R_FORK_THRD, 16'h100, 16'h200, lat, res, rmsg);
    check("fork0_msg", 32'(rmsg), 32'(CPU_R_FORK_DONE));
    check("fork0_res", 32'(res), 32'h0);
    check("fork0_lat", 32'(lat), 32'(exp_fork_lat(0)));
    check("fork0_valid", 32'(thrd_valid), 32'h01);
    check("fork0_cnt", 32'(thread_cnt), 32'h1);

    // Fill the table, then a ninth FORK fails.
    for (int i = 1; i < N; i++) req(CPU_R_FORK_THRD, 16'h100 + 16'(i * 16), 16'h0, lat, res, rmsg);
    check("full_valid", 32'(thrd_valid), 32'hFF);
    req(CPU_R_FORK_THRD, 16'h180, 16'h0, lat, res, rmsg);
    check("fork9_res", 32'(res), 32'hFFFF);
    check("fork9_lat", 32'(lat), 32'h8);
    check("fork9_cnt", 32'(thread_cnt), 32'h8);

    // STOP in slot 2, reuse by next FORK, unmatched STOP.
    do_reset();
    for (int i = 0; i < 3; i++) req(CPU_R_FORK_THRD, 16'h100 + 16'(i * 16), 16'h0, lat, res, rmsg);
    req(CPU_R_STOP_THRD, 16'h120, 16'h0, lat, res, rmsg);
    check("stop2_msg", 32'(rmsg), 32'(CPU_R_STOP_DONE));
    check("stop2_res", 32'(res), 32'h2);
    check("stop2_lat", 32'(lat), 32'h3);
    check("stop2_valid", 32'(thrd_valid), 32'h03);
    req(CPU_R_FORK_THRD, 16'h130, 16'h0, lat, res, rmsg);
    check("refork_res", 32'(res), 32'h2);
    check("refork_lat", 32'(lat), 32'(exp_fork_lat(2)));
    req(CPU_R_STOP_THRD, 16'h999, 16'h0, lat, res, rmsg);
    check("stopmiss_res", 32'(res), 32'hFFFF);
    check("stopmiss_lat", 32'(lat), 32'h8);
    check("stopmiss_valid", 32'(thrd_valid), 32'h07);
    check("stopmiss_cnt", 32'(thread_cnt), 32'h3);

    // Duplicate FORK.
    do_reset();
    req(CPU_R_FORK_THRD, 16'h100, 16'h0, lat, res, rmsg);
    req(CPU_R_FORK_THRD, 16'h100, 16'h0, lat, res, rmsg);
`ifdef THRD_DUP_GUARD_EN
    check("dup_res", 32'(res), 32'hFFFF);
    check("dup_lat", 32'(lat), 32'h8);
    check("dup_cnt", 32'(thread_cnt), 32'h1);
`else
    check("dup_res", 32'(res), 32'h1);
    check("dup_lat", 32'(lat), 32'h2);
    check("dup_cnt", 32'(thread_cnt), 32'h2);
`endif

    // Unknown opcode is ignored.
    @(negedge clk); #1 bus.cpu_msg_pulse = 1'b1; bus.cpu_msg_in = 4'h7;
    @(negedge clk); #1 bus.cpu_msg_pulse = 1'b0; bus.cpu_msg_in = '0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus.cpu_msg_out != '0) seen++; end
    check("ignored_code", 32'(seen), 32'h0);

    // Randomized traffic with a gated clock enable.
    oe_rand = 1'b1;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      req(($urandom_range(0, 2) != 0) ? CPU_R_FORK_THRD : CPU_R_STOP_THRD,
          16'h100 + 16'($urandom_range(0, 9) * 16), 16'($urandom), lat, res, rmsg);
    end

    // Reset in the middle of a long (unmatched) STOP search.
    @(negedge clk); #1;
    bus.cpu_msg_pulse = 1'b1; bus.cpu_msg_in = CPU_R_STOP_THRD; bus.addr_in = 16'hBEEF;
    wait_enabled_edge();
    @(negedge clk); #1 bus.cpu_msg_pulse = 1'b0; bus.cpu_msg_in = '0;
    repeat (3) wait_enabled_edge();
    #1 check("no_early_done", 32'(bus.cpu_msg_out), 32'h0);
    do_reset();
    oe_rand = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); if (bus.cpu_msg_out != '0) seen++; end
    check("no_done_after_rst", 32'(seen), 32'h0);
    check("post_rst_valid", 32'(thrd_valid), 32'h0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
